// File: rtl/rx_packet_capture_pkg.sv
// Shared types and constants for the RX FIFO packet capture block.
package rx_packet_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StRssi,
    StLqi,
    StReady,
    StDiscard
  } state_e;

  localparam int unsigned CRC_OK_BIT    = 7;
  localparam int unsigned STATUS_BYTES  = 2;
  localparam int unsigned RX_FIFO_DEPTH = 64;

endpackage

// File: rtl/rx_packet_capture_if.sv
// Byte-stream input and packet-consumer signals of rx_packet_capture.
interface rx_packet_capture_if;

  logic       capture_en;
  logic       new_data;
  logic [7:0] data_in;
  logic       rd_next;
  logic       pkt_ready;
  logic [7:0] pkt_len;
  logic [7:0] byte_out;
  logic [7:0] rssi;
  logic [6:0] lqi;
  logic       pkt_drop;
  logic       overrun;
  logic       busy;

  modport master (
    output capture_en, new_data, data_in, rd_next,
    input  pkt_ready, pkt_len, byte_out, rssi, lqi, pkt_drop, overrun, busy
  );

  modport slave (
    input  capture_en, new_data, data_in, rd_next,
    output pkt_ready, pkt_len, byte_out, rssi, lqi, pkt_drop, overrun, busy
  );

endinterface

// File: rtl/rx_payload_ram.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module rx_payload_ram #(
  parameter int unsigned DEPTH  = 61,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_packet_capture.sv
// Frames an SPI RX FIFO burst (len, payload, RSSI, LQI/CRC) into a buffered packet
// and hands the payload to the consumer one byte per rd_next.
module rx_packet_capture
  import rx_packet_capture_pkg::*;
#(
  parameter int unsigned MAX_LEN = RX_FIFO_DEPTH - 1 - STATUS_BYTES,
  parameter int unsigned ADDR_W  = 6
) (
  input logic                clk,
  input logic                rst,
  rx_packet_capture_if.slave bus
);

  state_e            state_q;
  logic [7:0]        pkt_len_q;
  logic [7:0]        rssi_q;
  logic [6:0]        lqi_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              pkt_drop_q;
  logic              overrun_q;

  logic [7:0]        last_idx;
  logic              len_ok;
  logic              ram_we;
  logic [7:0]        ram_rdata;

  assign last_idx = pkt_len_q - 8'd1;
  assign len_ok   = (bus.data_in != 8'd0) && (bus.data_in <= 8'(MAX_LEN));
  assign ram_we   = (state_q == StPayload) && bus.new_data;

  rx_payload_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pkt_len_q  <= 8'd0;
      rssi_q     <= 8'd0;
      lqi_q      <= 7'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_drop_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pkt_drop_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.new_data && bus.capture_en) begin
            if (len_ok) begin
              pkt_len_q <= bus.data_in;
              wr_ptr_q  <= '0;
              state_q   <= StPayload;
            end else begin
              pkt_drop_q <= 1'b1;
              state_q    <= StDiscard;
            end
          end
        end
        StPayload: begin
          // A strobe always wins over a falling capture_en; the abort lands next cycle.
          if (bus.new_data) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (8'(wr_ptr_q) == last_idx) begin
              state_q <= StRssi;
            end
          end else if (!bus.capture_en) begin
            pkt_drop_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StRssi: begin
          if (bus.new_data) begin
            rssi_q  <= bus.data_in;
            state_q <= StLqi;
          end else if (!bus.capture_en) begin
            pkt_drop_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StLqi: begin
          if (bus.new_data) begin
            lqi_q <= bus.data_in[6:0];
            if (bus.data_in[CRC_OK_BIT]) begin
              rd_ptr_q <= '0;
              state_q  <= StReady;
            end else begin
              pkt_drop_q <= 1'b1;
              state_q    <= StIdle;
            end
          end else if (!bus.capture_en) begin
            pkt_drop_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StReady: begin
          if (bus.new_data) begin
            overrun_q <= 1'b1;
          end
          if (bus.rd_next) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (8'(rd_ptr_q) == last_idx) begin
              state_q <= StIdle;
            end
          end
        end
        StDiscard: begin
          if (!bus.capture_en) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pkt_ready = (state_q == StReady);
  assign bus.busy      = (state_q != StIdle);
  assign bus.pkt_len   = pkt_len_q;
  assign bus.byte_out  = ram_rdata;
  assign bus.rssi      = rssi_q;
  assign bus.lqi       = lqi_q;
  assign bus.pkt_drop  = pkt_drop_q;
  assign bus.overrun   = overrun_q;

endmodule
